// File: rtl/ppg_sample_writer_if.sv
// Stream-in / read-out bundle of the PPG sample buffer writer.
interface ppg_sample_writer_if #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 13
);
  localparam int unsigned SUM_WIDTH = DATA_WIDTH + ADDR_WIDTH;

  logic                  start;
  logic                  s_valid;
  logic [DATA_WIDTH-1:0] s_data;
  logic                  s_ready;
  logic [ADDR_WIDTH-1:0] read_address;
  logic [DATA_WIDTH-1:0] data_out;
  logic [ADDR_WIDTH-1:0] write_address;
  logic [SUM_WIDTH-1:0]  sample_sum;
  logic                  loaded;
  logic                  busy;

  // Producer/consumer side: drives the stream and read address.
  modport master (
    output start, s_valid, s_data, read_address,
    input  s_ready, data_out, write_address, sample_sum, loaded, busy
  );

  // Writer side.
  modport slave (
    input  start, s_valid, s_data, read_address,
    output s_ready, data_out, write_address, sample_sum, loaded, busy
  );
endinterface

// File: rtl/ppg_sample_writer.sv
// Fills a PPG sample memory from a valid/ready stream, keeps a running sum,
// and serves registered reads to the mean/variance calculators.
module ppg_sample_writer #(
  parameter int unsigned DATA_WIDTH   = 16,
  parameter int unsigned MEMORY_DEPTH = 5968,
  parameter int unsigned ADDR_WIDTH   = 13
) (
  input  logic                clk,
  input  logic                reset,
  ppg_sample_writer_if.slave  bus
);

  localparam int unsigned SUM_WIDTH = DATA_WIDTH + ADDR_WIDTH;
  // Bits needed to index the memory array itself.
  localparam int unsigned IDX_WIDTH = (MEMORY_DEPTH > 1) ? $clog2(MEMORY_DEPTH) : 1;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MEMORY_DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    FULL = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic [SUM_WIDTH-1:0]  sum_q,   sum_d;
  logic                  loaded_q, loaded_d;
  logic                  busy_q,   busy_d;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;

  logic                  ready_c;
  logic                  accept_c;

  logic [DATA_WIDTH-1:0] mem [MEMORY_DEPTH];

  // Handshake: ready only while filling and not being restarted this cycle.
  always_comb begin
    ready_c  = (state_q == FILL) && !bus.start;
    accept_c = ready_c && bus.s_valid;
  end

  // Next-state, address, sum and status flag computation.
  always_comb begin
    state_d  = state_q;
    waddr_d  = waddr_q;
    sum_d    = sum_q;
    loaded_d = loaded_q;
    busy_d   = busy_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d  = FILL;
          waddr_d  = '0;
          sum_d    = '0;
          loaded_d = 1'b0;
          busy_d   = 1'b1;
        end
      end
      FILL: begin
        if (bus.start) begin
          // Restart: drop the partial record, keep filling.
          waddr_d = '0;
          sum_d   = '0;
        end else if (accept_c) begin
          waddr_d = waddr_q + ADDR_WIDTH'(1);
          sum_d   = sum_q + SUM_WIDTH'(bus.s_data);
          if (waddr_q == LAST_ADDR) begin
            state_d  = FULL;
            loaded_d = 1'b1;
            busy_d   = 1'b0;
          end
        end
      end
      FULL: begin
        if (bus.start) begin
          state_d  = FILL;
          waddr_d  = '0;
          sum_d    = '0;
          loaded_d = 1'b0;
          busy_d   = 1'b1;
        end
      end
      default: begin
        state_d  = IDLE;
        loaded_d = 1'b0;
        busy_d   = 1'b0;
      end
    endcase
  end

  // Read data: out-of-range addresses return zero.
  always_comb begin
    data_out_d = '0;
    if (32'(bus.read_address) < MEMORY_DEPTH) begin
      data_out_d = mem[bus.read_address[IDX_WIDTH-1:0]];
    end
  end

  // Control and read-data registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      waddr_q    <= '0;
      sum_q      <= '0;
      loaded_q   <= 1'b0;
      busy_q     <= 1'b0;
      data_out_q <= '0;
    end else begin
      state_q    <= state_d;
      waddr_q    <= waddr_d;
      sum_q      <= sum_d;
      loaded_q   <= loaded_d;
      busy_q     <= busy_d;
      data_out_q <= data_out_d;
    end
  end

  // Sample memory write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (accept_c) begin
      mem[waddr_q[IDX_WIDTH-1:0]] <= bus.s_data;
    end
  end

  assign bus.s_ready       = ready_c;
  assign bus.data_out      = data_out_q;
  assign bus.write_address = waddr_q;
  assign bus.sample_sum    = sum_q;
  assign bus.loaded        = loaded_q;
  assign bus.busy          = busy_q;

endmodule

// File: tb/tb_ppg_sample_writer.sv
// Directed bench for ppg_sample_writer: full-size record plus a depth-8 copy.
module tb_ppg_sample_writer;

  localparam int unsigned DW = 16;
  localparam int unsigned AW = 13;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_bad;
  int   ready_cnt;
  int   cycles;

  ppg_sample_writer_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();
  ppg_sample_writer_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) b8 ();

  ppg_sample_writer #(.DATA_WIDTH(DW), .MEMORY_DEPTH(5968), .ADDR_WIDTH(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  ppg_sample_writer #(.DATA_WIDTH(DW), .MEMORY_DEPTH(8), .ADDR_WIDTH(AW)) dut8 (
    .clk   (clk),
    .reset (reset),
    .bus   (b8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    reset = 1'b1;
    bus.start = 1'b0; bus.s_valid = 1'b0; bus.s_data = '0; bus.read_address = '0;
    b8.start  = 1'b0; b8.s_valid  = 1'b0; b8.s_data  = '0; b8.read_address  = '0;
    #1;
    check("rst_waddr",  64'(bus.write_address), 64'd0);
    check("rst_sum",    64'(bus.sample_sum),    64'd0);
    check("rst_loaded", 64'(bus.loaded),        64'd0);
    check("rst_busy",   64'(bus.busy),          64'd0);
    check("rst_dout",   64'(bus.data_out),      64'd0);
    step();
    reset = 1'b0;
    #1;
    check("idle_ready", 64'(bus.s_ready), 64'd0);

    // Depth-8 record, valid toggling every other cycle, all 0xFFFF.
    b8.start = 1'b1;
    step();
    b8.start = 1'b0;
    cycles = 0;
    for (int c = 0; c < 40 && !b8.loaded; c++) begin
      b8.s_valid = (c % 2 == 0);
      b8.s_data  = 16'hFFFF;
      step();
      cycles++;
    end
    b8.s_valid = 1'b0;
    check("d8_loaded", 64'(b8.loaded),        64'd1);
    check("d8_cycles", 64'(cycles),           64'd15);
    check("d8_waddr",  64'(b8.write_address), 64'd8);
    check("d8_sum",    64'(b8.sample_sum),    64'h7FFF8);
    for (int a = 0; a < 8; a++) begin
      b8.read_address = AW'(a);
      step();
      check("d8_read", 64'(b8.data_out), 64'hFFFF);
    end
    b8.read_address = AW'(8);
    step();
    check("d8_read_oob", 64'(b8.data_out), 64'd0);

    // Full record of 1..5968.
    bus.start = 1'b1;
    #1;
    check("start_idle_ready", 64'(bus.s_ready), 64'd0);
    step();
    bus.start = 1'b0;
    check("fill_busy",  64'(bus.busy),          64'd1);
    check("fill_waddr", 64'(bus.write_address), 64'd0);
    ready_cnt = 0;
    for (int i = 1; i <= 5968; i++) begin
      bus.s_valid = 1'b1;
      bus.s_data  = DW'(i);
      #1;
      if (bus.s_ready) ready_cnt++;
      if (i == 5968) begin
        check("pre_last_loaded", 64'(bus.loaded),        64'd0);
        check("pre_last_waddr",  64'(bus.write_address), 64'd5967);
      end
      step();
    end
    check("ready_cycles", 64'(ready_cnt),          64'd5968);
    check("full_loaded",  64'(bus.loaded),         64'd1);
    check("full_waddr",   64'(bus.write_address),  64'd5968);
    check("full_sum",     64'(bus.sample_sum),     64'd17811496);
    check("full_busy",    64'(bus.busy),           64'd0);

    // FULL with a sample held on the stream.
    bus.s_data = 16'hBEEF;
    #1;
    check("full_ready", 64'(bus.s_ready), 64'd0);
    bus.read_address = AW'(0);
    step();
    check("read_0", 64'(bus.data_out), 64'd1);
    bus.read_address = AW'(5967);
    step();
    check("read_5967", 64'(bus.data_out), 64'd5968);
    bus.read_address = AW'(5968);
    step();
    check("read_5968", 64'(bus.data_out), 64'd0);
    check("full_hold_waddr", 64'(bus.write_address), 64'd5968);
    check("full_hold_sum",   64'(bus.sample_sum),    64'd17811496);
    check("full_hold_ready", 64'(bus.s_ready),       64'd0);
    bus.read_address = AW'(0);
    step();
    check("full_hold_mem0", 64'(bus.data_out), 64'd1);

    // Restart from FULL.
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    check("refill_loaded", 64'(bus.loaded),        64'd0);
    check("refill_waddr",  64'(bus.write_address), 64'd0);
    check("refill_sum",    64'(bus.sample_sum),    64'd0);
    check("refill_busy",   64'(bus.busy),          64'd1);

    // Three accepts, then a restart with a sample offered.
    for (int k = 1; k <= 3; k++) begin
      bus.s_data = DW'(16 * k);
      step();
    end
    check("three_waddr", 64'(bus.write_address), 64'd3);
    check("three_sum",   64'(bus.sample_sum),    64'h60);
    bus.start  = 1'b1;
    bus.s_data = 16'hAAAA;
    #1;
    check("restart_ready", 64'(bus.s_ready), 64'd0);
    step();
    bus.start = 1'b0;
    check("restart_waddr", 64'(bus.write_address), 64'd0);
    check("restart_sum",   64'(bus.sample_sum),    64'd0);
    bus.s_data = 16'h0BCD;
    step();
    check("after_restart_waddr", 64'(bus.write_address), 64'd1);
    check("after_restart_sum",   64'(bus.sample_sum),    64'h0BCD);
    bus.s_valid      = 1'b0;
    bus.read_address = AW'(0);
    step();
    check("after_restart_mem0", 64'(bus.data_out), 64'h0BCD);
    bus.read_address = AW'(3);
    step();
    check("restart_no_write", 64'(bus.data_out), 64'd4);

    // Same-cycle read/write at address 5.
    bus.s_valid = 1'b1;
    bus.s_data = 16'h1111; step();
    bus.s_data = 16'h2222; step();
    bus.s_data = 16'h3333; step();
    bus.s_data = 16'h4444; step();
    bus.s_data = 16'h1234; step();
    check("rw_prep_waddr", 64'(bus.write_address), 64'd6);
    bus.s_valid = 1'b0;
    bus.start   = 1'b1;
    step();
    bus.start   = 1'b0;
    bus.s_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      bus.s_data = DW'(k + 1);
      step();
    end
    bus.s_data       = 16'h5678;
    bus.read_address = AW'(5);
    step();
    check("rw_old",   64'(bus.data_out),      64'h1234);
    check("rw_waddr", 64'(bus.write_address), 64'd6);
    bus.s_valid = 1'b0;
    step();
    check("rw_new", 64'(bus.data_out), 64'h5678);

    // Fill to address 100, then reset between edges.
    bus.read_address = AW'(1);
    bus.s_valid      = 1'b1;
    bus.s_data       = 16'h0007;
    for (int k = 6; k < 100; k++) step();
    bus.s_valid = 1'b0;
    check("mid_waddr", 64'(bus.write_address), 64'd100);
    check("mid_dout",  64'(bus.data_out),      64'd2);
    #2;
    reset = 1'b1;
    #1;
    check("async_waddr",  64'(bus.write_address), 64'd0);
    check("async_sum",    64'(bus.sample_sum),    64'd0);
    check("async_busy",   64'(bus.busy),          64'd0);
    check("async_loaded", 64'(bus.loaded),        64'd0);
    check("async_dout",   64'(bus.data_out),      64'd0);
    check("async_ready",  64'(bus.s_ready),       64'd0);
    @(posedge clk);
    #1;
    reset       = 1'b0;
    bus.s_valid = 1'b1;
    bus.s_data  = 16'h00FF;
    step(); step(); step();
    check("post_rst_waddr", 64'(bus.write_address), 64'd0);
    check("post_rst_sum",   64'(bus.sample_sum),    64'd0);
    check("post_rst_busy",  64'(bus.busy),          64'd0);
    check("post_rst_ready", 64'(bus.s_ready),       64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
